// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared definitions for the 8N1 UART link (receiver and
//                transmitter): state encodings, frame constants and the
//                default bit period.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // 8N1 framing
    localparam int c_DATA_BITS = 8;
    localparam int c_IDX_W     = $clog2(c_DATA_BITS);

    // 50 MHz system clock / 115200 baud
    localparam int c_CLOCK_PER_BIT_DEFAULT = 434;

    // Bit-period counter width; covers the largest legal bit period (2047)
    localparam int c_COUNT_W = 11;

    // Receiver state encodings
    localparam logic [2:0] c_IDLE_STATE      = 3'd0;
    localparam logic [2:0] c_START_BIT_STATE = 3'd1;
    localparam logic [2:0] c_DATA_STATE      = 3'd2;
    localparam logic [2:0] c_STOP_BIT_STATE  = 3'd3;
    localparam logic [2:0] c_CLEAR_STATE     = 3'd4;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit.
//                Both stages reset to RESET_VALUE.
//  Ports       : i_clk  - clock
//                i_rst  - asynchronous active-high reset
//                i_d    - asynchronous input
//                o_q    - synchronized output (second stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first, idle-high line. Oversamples
//                the serial line with the system clock, samples each bit at
//                mid-bit and presents the byte with a one-cycle done strobe,
//                or a one-cycle framing-error strobe if the stop bit is low.
//  Ports       : i_clk           - system clock, rising edge
//                i_rst           - asynchronous active-high reset
//                i_RX_bit        - serial line (asynchronous)
//                o_RX_byte[7:0]  - last good byte, held until the next one
//                o_RX_done       - 1-cycle pulse when o_RX_byte updates
//                o_receive_state - busy from start-bit detect to frame end
//                o_frame_error   - 1-cycle pulse when the stop bit is low
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_PER_BIT = c_CLOCK_PER_BIT_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_RX_bit,
    output logic [c_DATA_BITS-1:0] o_RX_byte,
    output logic                   o_RX_done,
    output logic                   o_receive_state,
    output logic                   o_frame_error
);

    // Terminal counts: half a bit to reach the middle of the start bit,
    // then whole bits so every later sample lands at mid-bit.
    localparam logic [c_COUNT_W-1:0] c_HALF_TC  = c_COUNT_W'(CLOCK_PER_BIT / 2 - 1);
    localparam logic [c_COUNT_W-1:0] c_BIT_TC   = c_COUNT_W'(CLOCK_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(c_DATA_BITS - 1);

    logic                   w_rx_s;

    logic [2:0]             r_state;
    logic [c_COUNT_W-1:0]   r_count;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_DATA_BITS-1:0] r_shift;
    logic [c_DATA_BITS-1:0] r_byte;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_ferr;

    logic [2:0]             w_state_next;
    logic [c_COUNT_W-1:0]   w_count_next;
    logic [c_IDX_W-1:0]     w_idx_next;
    logic [c_DATA_BITS-1:0] w_shift_next;
    logic [c_DATA_BITS-1:0] w_byte_next;
    logic                   w_done_next;
    logic                   w_busy_next;
    logic                   w_ferr_next;

    // Synchronizer resets to the idle level so a line that is already low
    // when reset releases still looks like a fresh falling edge.
    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_RX_bit),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE_STATE;
            r_count <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_byte  <= w_byte_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
            r_ferr  <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count + c_COUNT_W'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_byte_next  = r_byte;
        w_busy_next  = r_busy;
        // Strobes are only ever raised for the single cycle after the stop
        // bit is sampled, so they fall again in the first CLEAR cycle.
        w_done_next  = 1'b0;
        w_ferr_next  = 1'b0;

        case (r_state)
            c_IDLE_STATE: begin
                w_count_next = '0;
                w_idx_next   = '0;
                if (!w_rx_s) begin
                    w_state_next = c_START_BIT_STATE;
                    w_busy_next  = 1'b1;
                end
            end

            c_START_BIT_STATE: begin
                if (r_count == c_HALF_TC) begin
                    w_count_next = '0;
                    if (!w_rx_s) begin
                        w_state_next = c_DATA_STATE;
                    end else begin
                        // Line went back high before mid start bit: glitch
                        w_state_next = c_IDLE_STATE;
                        w_busy_next  = 1'b0;
                    end
                end
            end

            c_DATA_STATE: begin
                if (r_count == c_BIT_TC) begin
                    w_count_next        = '0;
                    w_shift_next[r_idx] = w_rx_s;
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = c_STOP_BIT_STATE;
                    end else begin
                        w_idx_next = r_idx + c_IDX_W'(1);
                    end
                end
            end

            c_STOP_BIT_STATE: begin
                if (r_count == c_BIT_TC) begin
                    w_count_next = '0;
                    w_busy_next  = 1'b0;
                    w_state_next = c_CLEAR_STATE;
                    if (w_rx_s) begin
                        w_byte_next = r_shift;
                        w_done_next = 1'b1;
                    end else begin
                        w_ferr_next = 1'b1;
                    end
                end
            end

            c_CLEAR_STATE: begin
                // Stay here while the line is low so a break condition
                // cannot be mistaken for a new start bit.
                w_count_next = '0;
                if (w_rx_s) begin
                    w_state_next = c_IDLE_STATE;
                end
            end

            default: begin
                w_count_next = '0;
                w_idx_next   = '0;
                w_busy_next  = 1'b0;
                w_state_next = c_IDLE_STATE;
            end
        endcase
    end

    assign o_RX_byte       = r_byte;
    assign o_RX_done       = r_done;
    assign o_receive_state = r_busy;
    assign o_frame_error   = r_ferr;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A fast instance (16 clocks
//                per bit) covers framing, glitches, breaks, reset and rate
//                tolerance; a second instance at 434 clocks per bit covers
//                the default rate. Expected bytes come from a simple frame
//                model: a frame with a high stop bit yields its byte, one with
//                a low stop bit yields a framing error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB      = 16;
    localparam int CPB_SLOW = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_slow = 1'b1;

    logic [7:0] byte16;
    logic       done16;
    logic       busy16;
    logic       ferr16;
    logic [7:0] byte434;
    logic       done434;
    logic       busy434;
    logic       ferr434;

    always #5 clk = ~clk;

    uart_rx #(.CLOCK_PER_BIT(CPB)) u_dut16 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_RX_bit        (rx),
        .o_RX_byte       (byte16),
        .o_RX_done       (done16),
        .o_receive_state (busy16),
        .o_frame_error   (ferr16)
    );

    uart_rx #(.CLOCK_PER_BIT(CPB_SLOW)) u_dut434 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_RX_bit        (rx_slow),
        .o_RX_byte       (byte434),
        .o_RX_done       (done434),
        .o_receive_state (busy434),
        .o_frame_error   (ferr434)
    );

    // ------------------------------------------------------------------
    // Observation: cycle counter and event logs, sampled on the falling edge
    // ------------------------------------------------------------------
    longint     cyc = 0;
    logic [7:0] got_q[$];
    longint     got_t[$];
    int         err_cnt = 0;
    int         busy_cnt = 0;
    int         excl_viol = 0;
    logic [7:0] slow_q[$];
    longint     slow_t[$];
    int         slow_err = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (done16) begin
            got_q.push_back(byte16);
            got_t.push_back(cyc);
        end
        if (ferr16) err_cnt = err_cnt + 1;
        if (busy16) busy_cnt = busy_cnt + 1;
        if ((done16 && ferr16) || (done434 && ferr434)) excl_viol = excl_viol + 1;
        if (done434) begin
            slow_q.push_back(byte434);
            slow_t.push_back(cyc);
        end
        if (ferr434) slow_err = slow_err + 1;
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int         exp_err = 0;
    logic [7:0] last_good = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    function automatic void model_frame(input logic [7:0] b, input logic stop_v);
        if (stop_v) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_err = exp_err + 1;
        end
    endfunction

    task automatic set_line(input bit slow, input logic v);
        if (slow) rx_slow = v;
        else      rx = v;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; the line is left at the
    // stop-bit level.
    task automatic send_frame(input bit slow, input logic [7:0] b,
                              input int period, input logic stop_v);
        set_line(slow, 1'b0);
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(slow, b[i]);
            repeat (period) @(negedge clk);
        end
        set_line(slow, stop_v);
        repeat (period) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        rx_slow = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (byte16 !== 8'h00) begin miscompares++; $display("FAIL reset_byte16 got %h want 00", byte16); end
        vectors++; if (done16 !== 1'b0) begin miscompares++; $display("FAIL reset_done16 got %b want 0", done16); end
        vectors++; if (busy16 !== 1'b0) begin miscompares++; $display("FAIL reset_busy16 got %b want 0", busy16); end
        vectors++; if (ferr16 !== 1'b0) begin miscompares++; $display("FAIL reset_ferr16 got %b want 0", ferr16); end
        vectors++; if (byte434 !== 8'h00) begin miscompares++; $display("FAIL reset_byte434 got %h want 00", byte434); end
        vectors++; if ({done434, busy434, ferr434} !== 3'b000) begin miscompares++; $display("FAIL reset_ctl434 got %b want 000", {done434, busy434, ferr434}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int     b0 = got_q.size();
        int     e0 = err_cnt;
        int     bz0 = busy_cnt;
        longint t0 = cyc;
        longint lat;
        send_frame(1'b0, 8'hA5, CPB, 1'b1);
        model_frame(8'hA5, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        vectors++; if (got_q.size() - b0 !== 1) begin miscompares++; $display("FAIL single_count got %0d want 1", got_q.size() - b0); end
        if (got_q.size() > b0) begin
            lat = got_t[b0] - t0;
            vectors++; if (got_q[b0] !== 8'hA5) begin miscompares++; $display("FAIL single_byte got %h want a5", got_q[b0]); end
            // 9.5 bit periods + 3 cycles, +/-2
            vectors++; if (lat < 153 || lat > 157) begin miscompares++; $display("FAIL single_latency got %0d want 153..157", lat); end
        end
        vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL single_ferr got %0d want 0", err_cnt - e0); end
        vectors++; if (busy_cnt - bz0 < 148 || busy_cnt - bz0 > 156) begin miscompares++; $display("FAIL single_busy_len got %0d want 148..156", busy_cnt - bz0); end
        vectors++; if (byte16 !== 8'hA5) begin miscompares++; $display("FAIL single_hold got %h want a5", byte16); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4] = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        int b0 = got_q.size();
        int e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, seq[i], CPB, 1'b1);
            model_frame(seq[i], 1'b1);
        end
        repeat (2 * CPB) @(negedge clk);
        vectors++; if (got_q.size() - b0 !== 4) begin miscompares++; $display("FAIL b2b_count got %0d want 4", got_q.size() - b0); end
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > b0 + i) begin
                vectors++; if (got_q[b0 + i] !== seq[i]) begin miscompares++; $display("FAIL b2b_byte%0d got %h want %h", i, got_q[b0 + i], seq[i]); end
            end
        end
        vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL b2b_ferr got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        int b0 = got_q.size();
        int e0 = err_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (busy16 !== 1'b1) begin miscompares++; $display("FAIL glitch_detect got %b want 1", busy16); end
        @(negedge clk);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        vectors++; if (busy16 !== 1'b0) begin miscompares++; $display("FAIL glitch_idle got %b want 0", busy16); end
        repeat (2 * CPB) @(negedge clk);
        vectors++; if (got_q.size() - b0 !== 0 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL glitch_events got done=%0d err=%0d want 0/0", got_q.size() - b0, err_cnt - e0); end
    endtask

    task automatic test_frame_error();
        int b0 = got_q.size();
        int e0 = err_cnt;
        int bz0 = busy_cnt;
        send_frame(1'b0, 8'h81, CPB, 1'b0);
        model_frame(8'h81, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL ferr_count got %0d want 1", err_cnt - e0); end
        vectors++; if (got_q.size() - b0 !== 0) begin miscompares++; $display("FAIL ferr_done got %0d want 0", got_q.size() - b0); end
        vectors++; if (byte16 !== last_good) begin miscompares++; $display("FAIL ferr_hold got %h want %h", byte16, last_good); end
        vectors++; if (busy16 !== 1'b0 || busy_cnt - bz0 > 156) begin miscompares++; $display("FAIL ferr_retrigger got busy=%b len=%0d want 0/<=156", busy16, busy_cnt - bz0); end
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        send_frame(1'b0, 8'h5A, CPB, 1'b1);
        model_frame(8'h5A, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        vectors++; if (err_cnt - e0 !== 1 || got_q.size() - b0 !== 1) begin miscompares++; $display("FAIL ferr_recover got err=%0d done=%0d want 1/1", err_cnt - e0, got_q.size() - b0); end
        vectors++; if (byte16 !== 8'h5A) begin miscompares++; $display("FAIL ferr_next_byte got %h want 5a", byte16); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h7E;
        int b0 = got_q.size();
        int e0 = err_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        vectors++; if (busy16 !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before got %b want 1", busy16); end
        rst = 1'b1;
        #1;
        vectors++; if ({busy16, done16, ferr16} !== 3'b000 || byte16 !== 8'h00) begin miscompares++; $display("FAIL rstmid_abort got ctl=%b byte=%h want 000/00", {busy16, done16, ferr16}, byte16); end
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(1'b0, 8'h42, CPB, 1'b1);
        model_frame(8'h42, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        vectors++; if (got_q.size() - b0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL rstmid_events got done=%0d err=%0d want 1/0", got_q.size() - b0, err_cnt - e0); end
        vectors++; if (byte16 !== 8'h42) begin miscompares++; $display("FAIL rstmid_byte got %h want 42", byte16); end
    endtask

    task automatic test_rate_tolerance();
        int periods [2] = '{CPB + 1, CPB - 1};
        for (int p = 0; p < 2; p++) begin
            int b0 = got_q.size();
            int e0 = err_cnt;
            send_frame(1'b0, 8'hC3, periods[p], 1'b1);
            model_frame(8'hC3, 1'b1);
            repeat (3 * CPB) @(negedge clk);
            vectors++; if (got_q.size() - b0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL rate%0d_events got done=%0d err=%0d want 1/0", periods[p], got_q.size() - b0, err_cnt - e0); end
            vectors++; if (byte16 !== 8'hC3) begin miscompares++; $display("FAIL rate%0d_byte got %h want c3", periods[p], byte16); end
        end
    endtask

    task automatic test_random();
        int b0 = got_q.size();
        int e0 = err_cnt;
        int x0 = exp_q.size();
        int xe0 = exp_err;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b = 8'($urandom);
            logic good = ($urandom_range(0, 3) != 0);
            int gap = good ? $urandom_range(0, 40) : $urandom_range(4, 40);
            send_frame(1'b0, b, CPB, good);
            model_frame(b, good);
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (3 * CPB) @(negedge clk);
        vectors++; if (got_q.size() - b0 !== exp_q.size() - x0) begin miscompares++; $display("FAIL rand_count got %0d want %0d", got_q.size() - b0, exp_q.size() - x0); end
        vectors++; if (err_cnt - e0 !== exp_err - xe0) begin miscompares++; $display("FAIL rand_ferr got %0d want %0d", err_cnt - e0, exp_err - xe0); end
        for (int i = 0; i < exp_q.size() - x0; i++) begin
            if (got_q.size() > b0 + i) begin
                vectors++; if (got_q[b0 + i] !== exp_q[x0 + i]) begin miscompares++; $display("FAIL rand_byte%0d got %h want %h", i, got_q[b0 + i], exp_q[x0 + i]); end
            end
        end
        vectors++; if (byte16 !== last_good) begin miscompares++; $display("FAIL rand_hold got %h want %h", byte16, last_good); end
    endtask

    task automatic test_default_rate();
        logic [7:0] b = 8'($urandom);
        longint     t0 = cyc;
        longint     lat;
        send_frame(1'b1, b, CPB_SLOW, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        vectors++; if (slow_q.size() !== 1 || slow_err !== 0) begin miscompares++; $display("FAIL slow_events got done=%0d err=%0d want 1/0", slow_q.size(), slow_err); end
        if (slow_q.size() > 0) begin
            lat = slow_t[0] - t0;
            vectors++; if (slow_q[0] !== b) begin miscompares++; $display("FAIL slow_byte got %h want %h", slow_q[0], b); end
            // 9.5 * 434 + 3 = 4126, +/-2
            vectors++; if (lat < 4124 || lat > 4128) begin miscompares++; $display("FAIL slow_latency got %0d want 4124..4128", lat); end
        end
    endtask

    task automatic test_strobe_exclusive();
        vectors++; if (excl_viol !== 0) begin miscompares++; $display("FAIL strobe_exclusive got %0d overlapping cycles want 0", excl_viol); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_rate_tolerance();
        test_random();
        test_default_rate();
        test_strobe_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
